// File: rtl/button_debouncer.sv
// Push-button conditioning: per-button 2-flop synchronizer, counter-based
// debounce FSM, and registered press strobe plus debounced level.

module button_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_BITS        = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse,
  output logic level
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_e;

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                pulse_q, pulse_d;
  logic                level_q, level_d;

  // Synchronizer: the FSM only ever looks at sync2_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      count_q <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  // Pulse defaults low so it can only ever be one cycle wide.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
    level_d = level_q;
    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_PEND;
          count_d = '0;
        end
      end
      PRESS_PEND: begin
        if (!sync2_q) begin
          state_d = RELEASED;
        end else if (count_q == CNT_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          count_d = count_q + CNT_BITS'(1);
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_PEND;
          count_d = '0;
        end
      end
      RELEASE_PEND: begin
        if (sync2_q) begin
          state_d = PRESSED;
        end else if (count_q == CNT_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
        end else begin
          count_d = count_q + CNT_BITS'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

module button_debouncer #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_BITS        = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level
);

  // Buttons are fully independent; one lane per bit.
  button_debounce_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_BITS       (CNT_BITS)
  ) u_lane [N_BTN-1:0] (
    .clock  (clock),
    .reset  (reset),
    .btn_raw(btn_in),
    .pulse  (btn_pulse),
    .level  (btn_level)
  );

endmodule

// File: tb/tb_button_debouncer.sv
// Table-driven bench for button_debouncer (DEBOUNCE_CYCLES=4): per-edge
// expectations queued as stimulus is driven, compared after each edge.

module tb_button_debouncer;

  localparam int N = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_pulse;
  logic [N-1:0] btn_level;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] exp_pulse;
    logic [N-1:0] exp_level;
    string        tag;
  } vec_t;

  typedef struct {
    logic [N-1:0] pulse;
    logic [N-1:0] level;
    string        tag;
    int           idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  button_debouncer #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(4),
    .CNT_BITS       (3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  always #5 clock = ~clock;

  task automatic add(input logic r, input logic [N-1:0] b, input logic [N-1:0] p,
                     input logic [N-1:0] l, input int n, input string tag);
    vec_t v;
    v.rst = r; v.btn = b; v.exp_pulse = p; v.exp_level = l; v.tag = tag;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    // Row i: inputs driven before edge i, outputs expected just after edge i.
    add(1, 3'b000, 3'b000, 3'b000, 2, "reset");
    // Clean press on bit 0: k = first 1 row, accept at k+6.
    add(0, 3'b001, 3'b000, 3'b000, 6,  "clean_pend");
    add(0, 3'b001, 3'b001, 3'b001, 1,  "clean_pulse");
    add(0, 3'b001, 3'b000, 3'b001, 43, "clean_hold");
    add(0, 3'b000, 3'b000, 3'b001, 6,  "clean_relpend");
    add(0, 3'b000, 3'b000, 3'b000, 4,  "clean_released");
    // Bounce reject on bit 1.
    add(0, 3'b010, 3'b000, 3'b000, 1,  "bounce_rej");
    add(0, 3'b000, 3'b000, 3'b000, 1,  "bounce_rej");
    add(0, 3'b010, 3'b000, 3'b000, 1,  "bounce_rej");
    add(0, 3'b000, 3'b000, 3'b000, 10, "bounce_rej");
    // Bounce then settle on bit 2, then bouncy release.
    add(0, 3'b100, 3'b000, 3'b000, 1,  "settle_bounce");
    add(0, 3'b000, 3'b000, 3'b000, 1,  "settle_bounce");
    add(0, 3'b100, 3'b000, 3'b000, 1,  "settle_bounce");
    add(0, 3'b000, 3'b000, 3'b000, 1,  "settle_bounce");
    add(0, 3'b100, 3'b000, 3'b000, 6,  "settle_pend");
    add(0, 3'b100, 3'b100, 3'b100, 1,  "settle_pulse");
    add(0, 3'b100, 3'b000, 3'b100, 10, "settle_hold");
    add(0, 3'b000, 3'b000, 3'b100, 1,  "rel_bounce");
    add(0, 3'b100, 3'b000, 3'b100, 1,  "rel_bounce");
    add(0, 3'b000, 3'b000, 3'b100, 1,  "rel_bounce");
    add(0, 3'b100, 3'b000, 3'b100, 1,  "rel_bounce");
    add(0, 3'b000, 3'b000, 3'b100, 6,  "rel_pend");
    add(0, 3'b000, 3'b000, 3'b000, 5,  "rel_done");
    // Simultaneous press on all bits.
    add(0, 3'b111, 3'b000, 3'b000, 6,  "simul_pend");
    add(0, 3'b111, 3'b111, 3'b111, 1,  "simul_pulse");
    add(0, 3'b111, 3'b000, 3'b111, 5,  "simul_hold");
    add(0, 3'b000, 3'b000, 3'b111, 6,  "simul_relpend");
    add(0, 3'b000, 3'b000, 3'b000, 4,  "simul_released");
    // Reset while bit 0 is PRESS_PEND with count=2, held through deassert.
    add(0, 3'b001, 3'b000, 3'b000, 5,  "rst_pend");
    add(1, 3'b001, 3'b000, 3'b000, 3,  "rst_mid");
    add(0, 3'b001, 3'b000, 3'b000, 6,  "rst_held_pend");
    add(0, 3'b001, 3'b001, 3'b001, 1,  "rst_held_pulse");
    add(0, 3'b001, 3'b000, 3'b001, 3,  "rst_held_hold");
    add(0, 3'b000, 3'b000, 3'b001, 6,  "rst_held_relpend");
    add(0, 3'b000, 3'b000, 3'b000, 4,  "rst_held_released");
    // Three clean press/release cycles on bit 1.
    for (int r = 0; r < 3; r++) begin
      add(0, 3'b010, 3'b000, 3'b000, 6, "repeat_pend");
      add(0, 3'b010, 3'b010, 3'b010, 1, "repeat_pulse");
      add(0, 3'b010, 3'b000, 3'b010, 2, "repeat_hold");
      add(0, 3'b000, 3'b000, 3'b010, 6, "repeat_relpend");
      add(0, 3'b000, 3'b000, 3'b000, 2, "repeat_released");
    end

    reset  = 1'b1;
    btn_in = '0;
    #1;
    check("reset_pulse", btn_pulse, 3'b000);
    check("reset_level", btn_level, 3'b000);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset  = vecs[i].rst;
      btn_in = vecs[i].btn;
      e.pulse = vecs[i].exp_pulse;
      e.level = vecs[i].exp_level;
      e.tag   = vecs[i].tag;
      e.idx   = i;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      checks++;
      if (btn_pulse !== e.pulse || btn_level !== e.level) begin
        failures++;
        $display("FAIL %s row %0d: pulse=%b level=%b expected pulse=%b level=%b",
                 e.tag, e.idx, btn_pulse, btn_level, e.pulse, e.level);
      end
    end

    // Asynchronous reset clears a live pulse and level with no clock edge.
    @(negedge clock);
    btn_in = 3'b100;
    repeat (6) @(posedge clock);
    @(posedge clock);
    #1;
    check("async_pre_pulse", btn_pulse, 3'b100);
    check("async_pre_level", btn_level, 3'b100);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pulse", btn_pulse, 3'b000);
    check("async_rst_level", btn_level, 3'b000);
    btn_in = 3'b000;
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("async_after_pulse", btn_pulse, 3'b000);
    check("async_after_level", btn_level, 3'b000);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
